// File: rtl/regfile_pkg.sv
// Shared types, constants and the port-slice helper for the multi-port register file.
// Read latency 0; no backpressure (writes are fire-and-forget, dropped during a clear sweep).
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_ZERO_ADDR = 0;
  localparam int RF_BUS_MAX   = 4096;
  localparam int RF_SLICE_MAX = 256;

  // Extract field idx of width w from a packed multi-port bus (zero-extended result).
  function automatic logic [RF_SLICE_MAX-1:0] rf_slice(input logic [RF_BUS_MAX-1:0] bus,
                                                        input int unsigned          idx,
                                                        input int unsigned          w);
    logic [RF_BUS_MAX-1:0]   sh;
    logic [RF_SLICE_MAX-1:0] mask;
    sh   = bus >> (idx * w);
    mask = ~({RF_SLICE_MAX{1'b1}} << w);
    return sh[RF_SLICE_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: sweeps entries 1..DEPTH-1, one per cycle, with busy/done outputs.
// Busy rises one cycle after clear_req is sampled; requests arriving while busy are ignored.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              clr_stb,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  rf_state_e         state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RF_IDLE;
      ptr        <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clear_req) begin
            state      <= RF_CLEAR;
            ptr        <= FIRST;
            clear_busy <= 1'b1;
            clear_done <= (FIRST == LAST);
          end
        end
        RF_CLEAR: begin
          // done is registered one step ahead so it is high exactly while ptr sits on the last entry
          if (ptr == LAST) begin
            state      <= RF_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
          end else begin
            ptr        <= ptr + FIRST;
            clear_done <= ((ptr + FIRST) == LAST);
          end
        end
        default: state <= RF_IDLE;
      endcase
    end
  end

  assign clr_stb  = clear_busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (r0 reads zero, highest write port wins); reads combinational, writes land next edge.
// Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN; writes are dropped while a clear sweep runs.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  parameter  int NR     = 2,
  parameter  int NW     = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 clear_done
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_ZERO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa [NW];
  logic [DATA_W-1:0] wd [NW];
  logic [NW-1:0]     wr_ok;
  logic [ADDR_W-1:0] ra [NR];
  logic [DATA_W-1:0] rd_val [NR];
  logic              clr_stb;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .clr_stb    (clr_stb),
    .clr_addr   (clr_addr)
  );

  always_comb begin
    for (int k = 0; k < NW; k++) begin
      wa[k]    = ADDR_W'(rf_slice(RF_BUS_MAX'(waddr), k, ADDR_W));
      wd[k]    = DATA_W'(rf_slice(RF_BUS_MAX'(wdata), k, DATA_W));
      wr_ok[k] = we[k] && !clr_stb && (wa[k] != ZERO_A) && (int'(wa[k]) < DEPTH);
    end
  end

  // Ascending port order means the highest-index accepted write lands last and wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_stb) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_ok[k]) mem[wa[k]] <= wd[k];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      ra[i]     = ADDR_W'(rf_slice(RF_BUS_MAX'(raddr), i, ADDR_W));
      rd_val[i] = '0;
      if ((ra[i] != ZERO_A) && (int'(ra[i]) < DEPTH)) rd_val[i] = mem[ra[i]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NW; k++) begin
        if (wr_ok[k] && (wa[k] == ra[i])) rd_val[i] = wd[k];
      end
`endif
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    assign rdata[i*DATA_W +: DATA_W] = rd_val[i];
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the cqu_mips five-stage pipeline, serving ID-stage operand reads and WB-stage writes. It generalises the 32×32 single-write register file to configurable width, depth, read-port count and write-port count. It keeps register 0 hard-wired to zero and adds deterministic multi-write priority. It also adds an optional same-cycle write-to-read bypass and a sequential clear engine with a busy/done handshake.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; 2..256
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- NR, 2, number of read ports
- NW, 1, number of write ports; 1..4
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- we  in  NW  per-port write enable
- waddr  in  NW*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- wdata  in  NW*DATA_W  write data, packed the same way
- raddr  in  NR*ADDR_W  read addresses, packed
- rdata  out  NR*DATA_W  read data, combinational from raddr
- clear_req  in  1  request to zero the whole file sequentially
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse on the last sweep cycle

## Operation
- Reset: while reset is high, all entries are 0, the FSM is IDLE, clear_busy=0 and clear_done=0. Reset applies immediately, regardless of the clock. rdata reflects the zeroed array.
- Reads: combinational. rdata[i] = entry[raddr[i]].
  - raddr=0 → 0.
  - raddr ≥ DEPTH (non-power-of-2 DEPTH) → 0.
- Writes: on the rising edge, each port with we[k]=1, waddr[k]≠0 and waddr[k]<DEPTH writes wdata[k]. Writes to 0 or to out-of-range addresses are discarded.
- Write collision: when several ports target the same address, the highest-index port wins.
- Clear FSM:
  - IDLE, clear_req=1 → CLEAR; the pointer loads 1.
  - CLEAR: each cycle zeroes entry[ptr] and increments ptr. While ptr=DEPTH-1, clear_done=1; the next state is IDLE.
  - clear_busy=1 in the CLEAR state.
  - clear_req is ignored while in CLEAR; a request is not queued.
- Writes during CLEAR are dropped entirely. Reads during CLEAR return current contents: entries below ptr read 0, entries at or above ptr keep their old values.
- reset asserted mid-sweep: the FSM returns to IDLE and all entries are 0. No clear_done pulse is produced.

## Timing
- Read latency: 0 cycles (combinational address → data).
- Write latency: data is visible on rdata in the cycle after the write edge. With bypass compiled in, it is visible in the same cycle.
- Clear: clear_req sampled at edge T. clear_busy rises after T and stays high for DEPTH-1 cycles. clear_done is high in the last of those cycles. clear_busy=0 and the file is all-zero after edge T+DEPTH-1.
- Back-to-back: clear_req held high across the return to IDLE starts a new sweep on the next edge.

## Configuration
- REGFILE_BYPASS_EN defined: when raddr[i] equals the waddr of an accepted write in the same cycle, rdata[i] = that wdata. Highest-index port wins. Address 0 still reads 0. No bypass during CLEAR, because those writes are dropped.
- Undefined: rdata always shows array contents. Same-cycle writes appear only after the clock edge.

## Structure
- Package regfile_pkg holds:
  - state enum: RF_IDLE, RF_CLEAR
  - RF_ZERO_ADDR = 0
  - a helper function that unpacks a port slice
- Sub-module regfile_clear_fsm owns the state, the pointer, clear_busy and clear_done. It outputs a clear strobe and the address to be cleared. The array, write-priority logic and read/bypass muxing live in the top module.

## Test plan
- Reset then read: assert reset mid-cycle with no clock edge → every raddr reads 0, clear_busy=0.
- Basic write/read (NW=1): write 0xDEADBEEF to r5 → next cycle raddr=5 returns 0xDEADBEEF. Write 0x1234 to r0 → r0 reads 0.
- Collision (NW=2): both ports write r7, port0=0xAAAA and port1=0x5555 → r7=0x5555.
- Bypass: write 0xCAFEF00D to r9 while raddr=9 → same cycle reads 0xCAFEF00D with REGFILE_BYPASS_EN defined, old value without it.
- Clear sweep (DEPTH=32): fill r1..r31 with index values, then pulse clear_req → clear_busy high for 31 cycles, clear_done on the 31st, all reads 0 afterwards. A write to r3 issued mid-sweep is dropped.
- Reset mid-clear: assert reset at sweep cycle 10 → immediate IDLE, all entries 0, no clear_done pulse.
